board_ram_arbiter: RTL and testbench
====================================

Name: board_ram_arbiter

Overview:
Time-shares one single-port synchronous board RAM between three users: the VGA display fetch, game-logic cell writes, and a whole-board clear sequencer. The RAM holds one COLOR_W-bit colour code per Tetris cell. The block sits between vga_controller (column/row/disp_ena), the game FSM, and the RAM. It produces a per-pixel cell colour for the pixel colour mapper.

Parameters:
BOARD_COLS, 10, cells per board row
BOARD_ROWS, 20, cells per board column
CELL_PX, 16, cell edge in pixels; must be a power of two
BOARD_X0, 240, first pixel column of the board
BOARD_Y0, 80, first pixel row of the board
COLOR_W, 3, colour code width; code 0 = empty
ADDR_W, 8, RAM address width; must satisfy 2^ADDR_W >= BOARD_COLS*BOARD_ROWS

Ports:
pixel_clk  in  1  pixel clock; the only clock
reset_n  in  1  asynchronous active-low reset
disp_ena  in  1  active-video qualifier from vga_controller
column  in  10  current pixel column
row  in  9  current pixel row
wr_req  in  1  game write request; level, held until wr_ack
wr_addr  in  ADDR_W  cell index = y*BOARD_COLS + x
wr_data  in  COLOR_W  colour code to write
wr_ack  out  1  one-cycle pulse; write accepted
clr_req  in  1  single-cycle pulse; start a board clear
clr_busy  out  1  high while a clear is in progress
ram_addr  out  ADDR_W  RAM address (registered)
ram_we  out  1  RAM write enable (registered)
ram_wdata  out  COLOR_W  RAM write data (registered)
ram_rdata  in  COLOR_W  RAM read data, valid one cycle after the address
cell_color  out  COLOR_W  colour of the cell under the pixel; 0 outside the board
cell_valid  out  1  pixel lies inside the board window

Behaviour:
- Reset values: every output is 0; the FSM is in IDLE; the clear counter is 0. Reset asserted mid-clear aborts the clear. Cells already cleared stay cleared.
- in_board = disp_ena and BOARD_X0 <= column < BOARD_X0+BOARD_COLS*CELL_PX and BOARD_Y0 <= row < BOARD_Y0+BOARD_ROWS*CELL_PX.
- Display index: cx = (column-BOARD_X0) >> log2(CELL_PX); cy likewise; addr = cy*BOARD_COLS + cx. Compute in ADDR_W+2 bits, then truncate.
- Port priority per cycle: display (when in_board) > clear > write. The port is "free" when in_board = 0.
- Display cycle: ram_addr <= display index and ram_we <= 0. Stage 1 registers in_board. Stage 2 registers cell_valid and cell_color = ram_rdata if stage1 in_board, else 0. The pipeline is always 2 cycles from column/row to cell_color/cell_valid, unaffected by arbitration.
- FSM states IDLE and CLEAR:
  - IDLE -> CLEAR on clr_req. The counter loads 0 and clr_busy rises the next cycle.
  - In CLEAR, on each free cycle: ram_addr <= counter, ram_wdata <= 0, ram_we <= 1, counter increments.
  - After writing index BOARD_COLS*BOARD_ROWS-1, return to IDLE. clr_busy falls in the same cycle the FSM enters IDLE.
  - clr_req while in CLEAR restarts the counter at 0 and stays in CLEAR.
- Write path: only in IDLE, only on a free cycle, only with wr_req = 1.
  - ram_addr <= wr_addr, ram_wdata <= wr_data, ram_we <= 1, wr_ack pulses in that same registered cycle.
  - The requester samples wr_ack and drops or replaces its request the next cycle. The arbiter must not ack twice in consecutive cycles for one held request: after an ack, ignore wr_req for one cycle.
  - wr_addr >= BOARD_COLS*BOARD_ROWS: acked normally, but ram_we stays 0 (write dropped).
- Simultaneous clr_req and wr_req in IDLE: clear wins and the write waits until clear completes.
- Any cycle with no granted write: ram_we = 0. ram_addr holds the display index when in_board; otherwise it holds its previous value.
- Starvation: writes can only be granted outside the board window. This is acceptable by design, since blanking plus the side margins give ≥ 480 free cycles per line.

Decomposition:
- Shared package (tetris_pkg): BOARD_COLS, BOARD_ROWS, CELL_PX, BOARD_X0, BOARD_Y0, COLOR_W, ADDR_W, the COLOR_EMPTY = 0 constant, and the FSM state encoding {IDLE, CLEAR}.
- One sub-module, board_pixel_mapper: combinational column/row -> in_board and cell index. It is reused later by the sprite overlay.
- The arbitration FSM, clear counter and read pipeline stay in board_ram_arbiter.

Test Plan:
- Reset then idle with disp_ena = 0 → all outputs 0, ram_we never 1.
- Pixel scan: column=240/row=80 → ram_addr=0; column=399/row=399 → ram_addr=199. With the RAM preloaded with cell 199 = 5, cell_color=5 and cell_valid=1 exactly 2 cycles after column=399/row=399 is presented. column=400/row=100 → cell_valid=0, cell_color=0.
- wr_req with wr_addr=37, wr_data=3, issued while in_board → no ack until in_board drops. Then ram_we=1, ram_addr=37, ram_wdata=3 and wr_ack high in the same cycle; the next cycle has no ack.
- wr_addr=200, wr_data=7 during blanking → wr_ack pulses and ram_we stays 0.
- clr_req during vertical blanking → exactly 200 writes of 0 to addresses 0..199 in order and clr_busy high throughout. A wr_req held concurrently is acked only after clr_busy falls. A second clr_req at count 50 restarts at address 0.
- reset_n pulsed low at clear count 120 → clr_busy=0, FSM in IDLE, no further writes.

Source files
------------

// File: rtl/tetris_pkg.sv
// Board geometry, colour encoding and arbiter state encoding shared by the
// board RAM arbiter, the pixel mapper and the sprite overlay.
package tetris_pkg;
  localparam int BOARD_COLS = 10;
  localparam int BOARD_ROWS = 20;
  localparam int CELL_PX    = 16;   // power of two; the index math shifts by CELL_SH
  localparam int BOARD_X0   = 240;
  localparam int BOARD_Y0   = 80;
  localparam int COLOR_W    = 3;
  localparam int ADDR_W     = 8;

  localparam int CELL_SH    = $clog2(CELL_PX);
  localparam int NUM_CELLS  = BOARD_COLS * BOARD_ROWS;

  localparam logic [COLOR_W-1:0] COLOR_EMPTY = '0;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } arb_state_e;
endpackage

// File: rtl/board_pixel_mapper.sv
// Combinational pixel -> board cell mapping: window test and row-major cell index.
module board_pixel_mapper
  import tetris_pkg::*;
(
  input  logic              disp_ena,
  input  logic [9:0]        column,
  input  logic [8:0]        row,
  output logic              in_board,
  output logic [ADDR_W-1:0] cell_idx
);
  // Index arithmetic runs two bits wider than the RAM address so the
  // intermediate product cannot wrap before the final truncation.
  localparam int IW = ADDR_W + 2;
  typedef logic [IW-1:0] idx_t;

  logic       in_x, in_y;
  logic [9:0] dx;
  logic [8:0] dy;
  idx_t       cx, cy, idx_w;

  // Window test plus cell coordinates from pixel offsets.
  always_comb begin
    in_x     = (column >= 10'(BOARD_X0)) && (column < 10'(BOARD_X0 + BOARD_COLS*CELL_PX));
    in_y     = (row >= 9'(BOARD_Y0)) && (row < 9'(BOARD_Y0 + BOARD_ROWS*CELL_PX));
    in_board = disp_ena && in_x && in_y;
    dx       = column - 10'(BOARD_X0);
    dy       = row - 9'(BOARD_Y0);
    cx       = idx_t'(dx >> CELL_SH);
    cy       = idx_t'(dy >> CELL_SH);
    idx_w    = cy * idx_t'(BOARD_COLS) + cx;
    cell_idx = idx_w[ADDR_W-1:0];
  end
endmodule

// File: rtl/board_ram_arbiter.sv
// Shares the single-port board RAM between display fetch (highest priority),
// the whole-board clear sequencer and game-logic cell writes, and returns the
// colour of the cell under the current pixel two cycles later.
module board_ram_arbiter
  import tetris_pkg::*;
(
  input  logic               pixel_clk,
  input  logic               reset_n,
  input  logic               disp_ena,
  input  logic [9:0]         column,
  input  logic [8:0]         row,
  input  logic               wr_req,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [COLOR_W-1:0] wr_data,
  output logic               wr_ack,
  input  logic               clr_req,
  output logic               clr_busy,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic               ram_we,
  output logic [COLOR_W-1:0] ram_wdata,
  input  logic [COLOR_W-1:0] ram_rdata,
  output logic [COLOR_W-1:0] cell_color,
  output logic               cell_valid
);
  logic              in_board;
  logic [ADDR_W-1:0] disp_idx;

  arb_state_e         state, state_nx;
  logic [ADDR_W-1:0]  cnt, cnt_nx;
  logic [ADDR_W-1:0]  addr_nx;
  logic               we_nx, ack_nx;
  logic [COLOR_W-1:0] wdata_nx;
  logic [1:0]         vld_pipe;

  board_pixel_mapper u_map (
    .disp_ena (disp_ena),
    .column   (column),
    .row      (row),
    .in_board (in_board),
    .cell_idx (disp_idx)
  );

  assign clr_busy   = (state == CLEAR);
  assign cell_valid = vld_pipe[1];

  // Port arbitration: display owns the port inside the window; otherwise the
  // clear sequencer, then a pending game write. A clr_req cycle only (re)arms
  // the counter. wr_ack high means the requester still holds the old request
  // this cycle, so it is not granted again.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    addr_nx  = ram_addr;
    wdata_nx = ram_wdata;
    we_nx    = 1'b0;
    ack_nx   = 1'b0;
    if (clr_req) begin
      state_nx = CLEAR;
      cnt_nx   = '0;
    end
    if (in_board) begin
      addr_nx = disp_idx;
    end else if (state == CLEAR && !clr_req) begin
      addr_nx  = cnt;
      wdata_nx = COLOR_EMPTY;
      we_nx    = 1'b1;
      cnt_nx   = cnt + ADDR_W'(1);
      if (cnt == ADDR_W'(NUM_CELLS - 1)) state_nx = IDLE;
    end else if (state == IDLE && !clr_req && wr_req && !wr_ack) begin
      addr_nx  = wr_addr;
      wdata_nx = wr_data;
      we_nx    = (wr_addr < ADDR_W'(NUM_CELLS));  // off-board writes are acked, then dropped
      ack_nx   = 1'b1;
    end
  end

  // FSM, clear counter and registered RAM port.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
      wr_ack    <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      ram_addr  <= addr_nx;
      ram_we    <= we_nx;
      ram_wdata <= wdata_nx;
      wr_ack    <= ack_nx;
    end
  end

  // Fixed two-stage read pipeline, independent of what the port is doing.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe   <= '0;
      cell_color <= COLOR_EMPTY;
    end else begin
      vld_pipe   <= {vld_pipe[0], in_board};
      cell_color <= vld_pipe[0] ? ram_rdata : COLOR_EMPTY;
    end
  end
endmodule

// File: tb/tb_board_ram_arbiter.sv
// Directed bench for board_ram_arbiter with a behavioural RAM and display model.
module tb_board_ram_arbiter;
  import tetris_pkg::*;

  logic               pixel_clk = 1'b0;
  logic               reset_n   = 1'b0;
  logic               disp_ena  = 1'b0;
  logic [9:0]         column    = '0;
  logic [8:0]         row       = '0;
  logic               wr_req    = 1'b0;
  logic [ADDR_W-1:0]  wr_addr   = '0;
  logic [COLOR_W-1:0] wr_data   = '0;
  logic               clr_req   = 1'b0;
  logic               wr_ack, clr_busy, ram_we, cell_valid;
  logic [ADDR_W-1:0]  ram_addr;
  logic [COLOR_W-1:0] ram_wdata, ram_rdata, cell_color;

  logic               pre_we   = 1'b0;
  logic [ADDR_W-1:0]  pre_addr = '0;
  logic [COLOR_W-1:0] pre_data = '0;
  logic [COLOR_W-1:0] mem [256] = '{default: '0};

  int tests = 0;
  int fails = 0;

  board_ram_arbiter dut (
    .pixel_clk (pixel_clk), .reset_n (reset_n), .disp_ena (disp_ena),
    .column (column), .row (row), .wr_req (wr_req), .wr_addr (wr_addr),
    .wr_data (wr_data), .wr_ack (wr_ack), .clr_req (clr_req),
    .clr_busy (clr_busy), .ram_addr (ram_addr), .ram_we (ram_we),
    .ram_wdata (ram_wdata), .ram_rdata (ram_rdata),
    .cell_color (cell_color), .cell_valid (cell_valid)
  );

  always #5 pixel_clk = ~pixel_clk;

  // Board RAM: data for the registered address is visible during the next cycle.
  assign ram_rdata = mem[ram_addr];
  always @(posedge pixel_clk) begin
    if (ram_we)      mem[ram_addr] <= ram_wdata;
    else if (pre_we) mem[pre_addr] <= pre_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Geometry straight from the board description, in plain integer arithmetic.
  function automatic void pix_model(input logic de, input int c, input int r,
                                    output bit inb, output int idx);
    inb = de && c >= BOARD_X0 && c < BOARD_X0 + BOARD_COLS*CELL_PX
             && r >= BOARD_Y0 && r < BOARD_Y0 + BOARD_ROWS*CELL_PX;
    idx = inb ? ((r - BOARD_Y0) / CELL_PX) * BOARD_COLS + (c - BOARD_X0) / CELL_PX : 0;
  endfunction

  // Per-cycle compare: display fetch address one cycle after the pixel,
  // cell colour/valid two cycles after the pixel.
  bit               p_inb = 0, q_inb = 0;
  int               p_idx = 0;
  logic [COLOR_W-1:0] q_col = '0;
  initial forever begin
    @(negedge pixel_clk);
    if (!reset_n) begin
      p_inb = 0; q_inb = 0; q_col = '0;
    end else begin
      if (p_inb) begin
        check("disp_addr", ram_addr, p_idx);
        check("disp_we", ram_we, 0);
      end
      check("cell_valid", cell_valid, q_inb);
      check("cell_color", cell_color, q_col);
      q_inb = p_inb;
      q_col = p_inb ? mem[p_idx] : '0;
      pix_model(disp_ena, int'(column), int'(row), p_inb, p_idx);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic set_pix(input logic de, input int c, input int r);
    disp_ena = de;
    column   = 10'(c);
    row      = 9'(r);
  endtask

  task automatic preload(input int a, input int d);
    pre_addr = ADDR_W'(a);
    pre_data = COLOR_W'(d);
    pre_we   = 1'b1;
    tick();
    pre_we   = 1'b0;
  endtask

  int n, we_cnt;
  bit restarted, sent;
  int scan_c[8] = '{239, 240, 255, 256, 399, 400, 320, 250};
  int scan_r[8] = '{100,  79,  95,  96, 399,  80, 400, 250};

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_wr_ack", wr_ack, 0);
    check("rst_clr_busy", clr_busy, 0);
    check("rst_cell_color", cell_color, 0);
    check("rst_cell_valid", cell_valid, 0);
    reset_n = 1'b1;
    we_cnt = 0;
    repeat (20) begin tick(); if (ram_we) we_cnt++; end
    check("idle_no_we", we_cnt, 0);

    // Pixel scan with hand-computed addresses and colours
    preload(0, 2); preload(199, 5); preload(37, 1);
    set_pix(1, 240, 80);  tick();
    check("addr_240_80", ram_addr, 0);
    set_pix(1, 399, 399); tick();
    check("addr_399_399", ram_addr, 199);
    check("color_240_80", cell_color, 2);
    set_pix(1, 400, 100); tick();
    check("color_399_399", cell_color, 5);
    check("valid_399_399", cell_valid, 1);
    set_pix(0, 0, 0);     tick();
    check("valid_400_100", cell_valid, 0);
    check("color_400_100", cell_color, 0);
    for (int i = 0; i < 8; i++) begin
      set_pix(i != 7, scan_c[i], scan_r[i]);
      tick();
    end
    set_pix(0, 0, 0); tick(); tick();

    // Write held while in the board window, granted once the port is free
    set_pix(1, 300, 200);
    wr_req = 1'b1; wr_addr = 8'd37; wr_data = 3'd3;
    repeat (4) begin tick(); check("wr_ack_inboard", wr_ack, 0); end
    set_pix(0, 0, 0); tick();
    check("wr_ack", wr_ack, 1);
    check("wr_we", ram_we, 1);
    check("wr_addr", ram_addr, 37);
    check("wr_wdata", ram_wdata, 3);
    tick();
    check("wr_ack_once", wr_ack, 0);
    check("wr_we_once", ram_we, 0);
    wr_req = 1'b0; tick();
    check("mem37", mem[37], 3);

    // Off-board write address: acked, not written
    wr_req = 1'b1; wr_addr = 8'd200; wr_data = 3'd7; tick();
    check("oob_ack", wr_ack, 1);
    check("oob_we", ram_we, 0);
    wr_req = 1'b0; tick();
    check("oob_ack_drop", wr_ack, 0);
    check("mem200", mem[200], 0);

    // Full clear with display interruptions and a concurrent write request
    wr_req = 1'b1; wr_addr = 8'd5; wr_data = 3'd6; clr_req = 1'b1; tick();
    clr_req = 1'b0;
    check("clr_busy_rise", clr_busy, 1);
    check("clr_wr_ack0", wr_ack, 0);
    n = 0;
    for (int cyc = 0; cyc < 600 && n < NUM_CELLS; cyc++) begin
      set_pix((cyc % 7) == 3, 300, 200);
      tick();
      if (ram_we) begin
        check("clr_addr", ram_addr, n);
        check("clr_data", ram_wdata, 0);
        n++;
      end
      check("clr_busy", clr_busy, n < NUM_CELLS);
      check("clr_wr_wait", wr_ack, 0);
    end
    check("clr_count", n, NUM_CELLS);
    set_pix(0, 0, 0); tick();
    check("post_clr_ack", wr_ack, 1);
    check("post_clr_addr", ram_addr, 5);
    check("post_clr_we", ram_we, 1);
    check("post_clr_wdata", ram_wdata, 6);
    wr_req = 1'b0; tick();
    check("mem5", mem[5], 6);
    check("mem37_clr", mem[37], 0);
    check("mem199_clr", mem[199], 0);

    // Second clr_req at count 50 restarts from address 0
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    n = 0; restarted = 0;
    for (int cyc = 0; cyc < 800 && !(restarted && n == NUM_CELLS); cyc++) begin
      sent = !restarted && n == 50;
      clr_req = sent;
      tick();
      clr_req = 1'b0;
      if (sent) begin
        restarted = 1; n = 0;
      end else if (ram_we) begin
        check("rst_clr_addr", ram_addr, n);
        n++;
      end
    end
    check("restart_seen", restarted, 1);
    check("restart_count", n, NUM_CELLS);
    check("restart_busy_fall", clr_busy, 0);

    // Reset in the middle of a clear
    preload(119, 4); preload(150, 4);
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    n = 0;
    for (int cyc = 0; cyc < 400 && n < 120; cyc++) begin
      tick();
      if (ram_we) n++;
    end
    check("pre_reset_count", n, 120);
    tick();
    reset_n = 1'b0; #1;
    check("midrst_busy", clr_busy, 0);
    check("midrst_we", ram_we, 0);
    tick(); tick();
    reset_n = 1'b1;
    we_cnt = 0;
    repeat (20) begin tick(); if (ram_we) we_cnt++; end
    check("midrst_no_we", we_cnt, 0);
    check("midrst_busy_idle", clr_busy, 0);
    check("mem119_kept", mem[119], 0);
    check("mem150_untouched", mem[150], 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
